// File: rtl/board_manager_if.sv
// Move-request / referee-status bundle between fsm_controller (master)
// and board_manager (slave).
interface board_manager_if;
  // Strobes are single-cycle requests sampled on every rising edge; there is
  // no ready. The referee answers one edge later with ill_move (pulse) while
  // board, move_count, win, winner and no_space are always-valid levels.
  logic        p1_play;
  logic        p2_play;
  logic [3:0]  p1_pos;
  logic [3:0]  p2_pos;
  logic        ill_move;
  logic        no_space;
  logic        win;
  logic [1:0]  winner;
  logic [17:0] board;
  logic [3:0]  move_count;

  modport master (
    output p1_play, p2_play, p1_pos, p2_pos,
    input  ill_move, no_space, win, winner, board, move_count
  );

  modport slave (
    input  p1_play, p2_play, p1_pos, p2_pos,
    output ill_move, no_space, win, winner, board, move_count
  );
endinterface

// File: rtl/board_manager.sv
// Tic-tac-toe board holder and referee: validates moves, counts them,
// detects three-in-a-row and freezes the board once the game is over.
module board_manager #(
  parameter logic [1:0] P1_MARK = 2'b01,
  parameter logic [1:0] P2_MARK = 2'b10
) (
  input  logic          clk,
  input  logic          reset,
  board_manager_if.slave bus
);

  logic [8:0][1:0] cells_q;
  logic [3:0]      count_q;
  logic            ill_q;

  logic            only_p1;
  logic            only_p2;
  logic            both;
  logic [3:0]      pos;
  logic [1:0]      mark;
  logic            pos_ok;
  logic            target_empty;
  logic            accept;
  logic            reject;
  logic            game_over;
  logic [7:0][1:0] line_mark;
  logic [1:0]      win_mark;

  // Returns the shared mark of a full line, or empty when the line is open.
  function automatic logic [1:0] mark3(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
  endfunction

  assign line_mark[0] = mark3(cells_q[0], cells_q[1], cells_q[2]);
  assign line_mark[1] = mark3(cells_q[3], cells_q[4], cells_q[5]);
  assign line_mark[2] = mark3(cells_q[6], cells_q[7], cells_q[8]);
  assign line_mark[3] = mark3(cells_q[0], cells_q[3], cells_q[6]);
  assign line_mark[4] = mark3(cells_q[1], cells_q[4], cells_q[7]);
  assign line_mark[5] = mark3(cells_q[2], cells_q[5], cells_q[8]);
  assign line_mark[6] = mark3(cells_q[0], cells_q[4], cells_q[8]);
  assign line_mark[7] = mark3(cells_q[2], cells_q[4], cells_q[6]);

  // The board freezes at the first win, so every winning line carries the
  // same mark and a plain OR yields the unique winner.
  always_comb begin
    win_mark = 2'b00;
    for (int l = 0; l < 8; l++) win_mark = win_mark | line_mark[l];
  end

  assign bus.win        = (win_mark != 2'b00);
  assign bus.winner     = win_mark;
  assign bus.no_space   = (count_q == 4'd9);
  assign bus.board      = cells_q;
  assign bus.move_count = count_q;
  assign bus.ill_move   = ill_q;
  assign game_over      = bus.win | bus.no_space;

  assign only_p1 = bus.p1_play & ~bus.p2_play;
  assign only_p2 = bus.p2_play & ~bus.p1_play;
  assign both    = bus.p1_play &  bus.p2_play;
  assign pos     = only_p1 ? bus.p1_pos : bus.p2_pos;
  assign mark    = only_p1 ? P1_MARK : P2_MARK;
  assign pos_ok  = (pos <= 4'd8);

  always_comb begin
    target_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pos == 4'(i)) target_empty = (cells_q[i] == 2'b00);
    end
  end

  assign accept = (only_p1 | only_p2) & pos_ok & target_empty;
  assign reject = both | ((only_p1 | only_p2) & ~(pos_ok & target_empty));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cells_q <= '0;
      count_q <= 4'd0;
      ill_q   <= 1'b0;
    end else if (game_over) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= reject;
      if (accept) begin
        count_q <= count_q + 4'd1;
        for (int i = 0; i < 9; i++) begin
          if (pos == 4'(i)) cells_q[i] <= mark;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_manager.sv
// Directed bench for board_manager: a game-level model checked every cycle
// plus literal expectations along a scripted set of games.
module tb_board_manager;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  board_manager_if bus();

  board_manager dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- model: the game as arrays of marks ----------------
  int m_cell[9] = '{default: 0};
  int m_count = 0;
  bit m_ill = 1'b0;

  function automatic int m_winner();
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++) begin
      if (m_cell[lines[l][0]] != 0 &&
          m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
          m_cell[lines[l][1]] == m_cell[lines[l][2]])
        return m_cell[lines[l][0]];
    end
    return 0;
  endfunction

  function automatic logic [17:0] m_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b = b | (18'(m_cell[i]) << (2 * i));
    return b;
  endfunction

  function automatic bit m_over();
    return (m_winner() != 0) || (m_count == 9);
  endfunction

  function automatic int req_pos();
    return bus.p1_play ? int'(bus.p1_pos) : int'(bus.p2_pos);
  endfunction

  function automatic bit req_legal();
    int p = req_pos();
    return (p <= 8) && (m_cell[p] == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) m_cell[i] <= 0;
      m_count <= 0;
      m_ill   <= 1'b0;
    end else if (m_over() || (!bus.p1_play && !bus.p2_play)) begin
      m_ill <= 1'b0;
    end else if (bus.p1_play && bus.p2_play) begin
      m_ill <= 1'b1;
    end else if (req_legal()) begin
      m_cell[req_pos()] <= bus.p1_play ? 1 : 2;
      m_count <= m_count + 1;
      m_ill   <= 1'b0;
    end else begin
      m_ill <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_board",    32'(bus.board),      32'(m_board()));
      check("cyc_count",    32'(bus.move_count), 32'(m_count));
      check("cyc_ill",      32'(bus.ill_move),   32'(m_ill));
      check("cyc_win",      32'(bus.win),        32'(m_winner() != 0));
      check("cyc_winner",   32'(bus.winner),     32'(m_winner()));
      check("cyc_no_space", 32'(bus.no_space),   32'(m_count == 9));
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; presents the request for one edge and
  // returns just after that edge, when the result is visible.
  task automatic strobe(input bit a, input bit b, input logic [3:0] pa,
                        input logic [3:0] pb);
    bus.p1_play = a;
    bus.p2_play = b;
    bus.p1_pos  = pa;
    bus.p2_pos  = pb;
    @(posedge clk);
    #1;
    bus.p1_play = 1'b0;
    bus.p2_play = 1'b0;
  endtask

  task automatic p1(input logic [3:0] p); strobe(1'b1, 1'b0, p, 4'd0); endtask
  task automatic p2(input logic [3:0] p); strobe(1'b0, 1'b1, 4'd0, p); endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    bus.p1_play = 1'b0;
    bus.p2_play = 1'b0;
    bus.p1_pos  = 4'd0;
    bus.p2_pos  = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // reset then idle
    check("rst_board",    32'(bus.board),      32'h0);
    check("rst_count",    32'(bus.move_count), 32'h0);
    check("rst_ill",      32'(bus.ill_move),   32'h0);
    check("rst_win",      32'(bus.win),        32'h0);
    check("rst_winner",   32'(bus.winner),     32'h0);
    check("rst_no_space", 32'(bus.no_space),   32'h0);

    // legal alternate moves
    p1(4'd4);
    check("p1_at4_board", 32'(bus.board),      32'h00100);
    p2(4'd0);
    check("p2_at0_board", 32'(bus.board),      32'h00102);
    check("two_moves",    32'(bus.move_count), 32'd2);

    // illegal: occupied, out of range, both strobes
    p2(4'd4);
    check("occ_ill",      32'(bus.ill_move),   32'd1);
    check("occ_board",    32'(bus.board),      32'h00102);
    strobe(1'b0, 1'b0, 4'd0, 4'd0);
    check("ill_pulse_end", 32'(bus.ill_move),  32'd0);
    p1(4'd12);
    check("range_ill",    32'(bus.ill_move),   32'd1);
    check("range_count",  32'(bus.move_count), 32'd2);
    strobe(1'b1, 1'b1, 4'd3, 4'd3);
    check("both_ill",     32'(bus.ill_move),   32'd1);
    check("both_cell3",   32'(bus.board[7:6]), 32'd0);

    // held legal strobe: second edge sees its own mark
    bus.p1_play = 1'b1;
    bus.p1_pos  = 4'd8;
    @(posedge clk);
    #1;
    check("held_first",   32'(bus.ill_move),   32'd0);
    check("held_count",   32'(bus.move_count), 32'd3);
    @(posedge clk);
    #1;
    bus.p1_play = 1'b0;
    check("held_second",  32'(bus.ill_move),   32'd1);
    check("held_board",   32'(bus.board),      32'h10102);

    // mid-game reset between edges takes effect at once
    #3 reset = 1'b0;
    #1;
    check("async_board",  32'(bus.board),      32'h0);
    check("async_count",  32'(bus.move_count), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    p1(4'd5);
    check("resume_board", 32'(bus.board),      32'h00400);
    do_reset();

    // win on the top row, then freeze
    p1(4'd0); p2(4'd3); p1(4'd1); p2(4'd4); p1(4'd2);
    check("win_flag",     32'(bus.win),        32'd1);
    check("win_who",      32'(bus.winner),     32'd1);
    check("win_count",    32'(bus.move_count), 32'd5);
    check("win_board",    32'(bus.board),      32'h00295);
    p2(4'd8);
    check("frozen_ill",   32'(bus.ill_move),   32'd0);
    check("frozen_board", 32'(bus.board),      32'h00295);
    do_reset();

    // draw: full board with no line
    p1(4'd0); p2(4'd1); p1(4'd2); p2(4'd4); p1(4'd3);
    p2(4'd6); p1(4'd7); p2(4'd8); p1(4'd5);
    check("draw_ns",      32'(bus.no_space),   32'd1);
    check("draw_win",     32'(bus.win),        32'd0);
    check("draw_count",   32'(bus.move_count), 32'd9);
    check("draw_board",   32'(bus.board),      32'h26659);
    strobe(1'b1, 1'b1, 4'd4, 4'd4);
    check("draw_frozen",  32'(bus.ill_move),   32'd0);
    do_reset();

    // ninth move completing a line: win and no_space together
    p1(4'd0); p2(4'd1); p1(4'd2); p2(4'd4); p1(4'd3);
    p2(4'd5); p1(4'd7); p2(4'd8); p1(4'd6);
    check("last_win",     32'(bus.win),        32'd1);
    check("last_ns",      32'(bus.no_space),   32'd1);
    check("last_winner",  32'(bus.winner),     32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
